// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//   Groups the handshake signals of the fetch queue: the PC-unit request
//   channel, the redirect/flush strobe, the instruction-memory request and
//   response channels, and the decode-facing instruction channel.
//
//   Modports:
//     slave  - the fetch queue itself (consumes PCs and memory responses,
//              produces memory requests and instructions)
//     master - the surrounding environment (PC unit, memory, decode)
//
//   Signals:
//     pc, pc_valid, pc_ready            PC unit -> fetch queue
//     redirect                          flush of queue and in-flight fetches
//     imem_req_valid/ready/addr         fetch queue -> instruction memory
//     imem_rsp_valid/data               instruction memory -> fetch queue
//     instr_valid/ready, instr, instr_pc fetch queue -> decode
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             pc_ready;
    logic             redirect;
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;

    modport slave (
        input  pc,
        input  pc_valid,
        output pc_ready,
        input  redirect,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport master (
        output pc,
        output pc_valid,
        input  pc_ready,
        output redirect,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch stage behind the PC unit. Each accepted PC is issued
//   in order to instruction memory and a queue slot is reserved for it; the
//   in-order responses fill the slots, and {instr, pc} pairs are delivered
//   to decode over a valid/ready handshake. A redirect flushes the queue
//   and arranges for responses still in flight to be dropped.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous, active-low reset
//     bus          fetch_queue_if.slave (PC, memory and decode channels)
//   Optional (macro FETCH_QUEUE_PERF_EN defined):
//     perf_fetched responses written into the queue (saturating)
//     perf_dropped responses discarded (saturating)
//     perf_stall   cycles with pc_valid high and no issue slot (saturating)
//
//   Parameters:
//     WIDTH  address / instruction width
//     DEPTH  number of queue entries (power of two, >= 2)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped,
    output logic [31:0]       perf_stall,
`endif
    fetch_queue_if.slave      bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Slot storage; contents are qualified by the pointers, so not reset.
    logic [WIDTH-1:0] slot_pc_q    [DEPTH];
    logic [WIDTH-1:0] slot_instr_q [DEPTH];

    logic [PtrW-1:0] alloc_ptr_q, alloc_ptr_d;
    // fill/read pointers carry an extra wrap bit so their difference is the
    // filled count even when the queue is completely filled.
    logic [CntW-1:0] fill_ptr_q, fill_ptr_d;
    logic [CntW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] used_q, used_d;
    logic [CntW-1:0] discard_q, discard_d;

    logic [CntW-1:0] filled;
    logic [CntW-1:0] unfilled;
    logic [CntW:0]   occupancy;
    logic            can_issue;
    logic            issue;
    logic            rsp_drop;
    logic            rsp_fill;
    logic            deq;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    always_comb begin
        filled    = fill_ptr_q - rd_ptr_q;
        unfilled  = used_q - filled;
        // Slots reserved for dropped responses still count against capacity,
        // otherwise a late stale response could race a fresh allocation.
        occupancy = {1'b0, used_q} + {1'b0, discard_q};
        // rst gating keeps the request side quiet while reset is held.
        can_issue = rst && !bus.redirect && (occupancy < (CntW + 1)'(DEPTH));
        issue     = bus.pc_valid && can_issue && bus.imem_req_ready;
        rsp_drop  = bus.imem_rsp_valid && (discard_q != '0);
        // A response with nothing outstanding is ignored.
        rsp_fill  = bus.imem_rsp_valid && (discard_q == '0) && (unfilled != '0);
        deq       = (filled != '0) && bus.instr_ready && !bus.redirect;
    end

    // -----------------------------------------------------------------------
    // Next-state
    // -----------------------------------------------------------------------
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        used_d      = used_q;
        discard_d   = discard_q;

        if (bus.redirect) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            used_d      = '0;
            // Everything allocated but not yet filled is still coming back
            // from memory; a response landing this cycle is one fewer.
            discard_d   = discard_q + unfilled - CntW'(rsp_drop || rsp_fill);
        end else begin
            alloc_ptr_d = alloc_ptr_q + PtrW'(issue);
            fill_ptr_d  = fill_ptr_q + CntW'(rsp_fill);
            rd_ptr_d    = rd_ptr_q + CntW'(deq);
            used_d      = used_q + CntW'(issue) - CntW'(deq);
            discard_d   = discard_q - CntW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            used_q      <= '0;
            discard_q   <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            used_q      <= used_d;
            discard_q   <= discard_d;
        end
    end

    // issue is already blocked during redirect; the fill write is not.
    always_ff @(posedge clk) begin
        if (issue) begin
            slot_pc_q[alloc_ptr_q] <= bus.pc;
        end
        if (rsp_fill && !bus.redirect) begin
            slot_instr_q[fill_ptr_q[PtrW-1:0]] <= bus.imem_rsp_data;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.imem_req_valid = bus.pc_valid && can_issue;
        bus.imem_req_addr  = bus.pc;
        bus.pc_ready       = issue;
        bus.instr_valid    = (filled != '0);
        bus.instr          = slot_instr_q[rd_ptr_q[PtrW-1:0]];
        bus.instr_pc       = slot_pc_q[rd_ptr_q[PtrW-1:0]];
    end

`ifdef FETCH_QUEUE_PERF_EN
    // -----------------------------------------------------------------------
    // Performance counters (saturating, unaffected by redirect)
    // -----------------------------------------------------------------------
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        ev_fetched;
    logic        ev_dropped;
    logic        ev_stall;

    always_comb begin
        ev_fetched = rsp_fill && !bus.redirect;
        // A response that would have filled is dropped by a same-cycle flush.
        ev_dropped = rsp_drop || (rsp_fill && bus.redirect);
        ev_stall   = bus.pc_valid && !can_issue;

        perf_fetched_d = perf_fetched_q;
        perf_dropped_d = perf_dropped_q;
        perf_stall_d   = perf_stall_q;
        if (ev_fetched && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (ev_dropped && (perf_dropped_q != '1)) begin
            perf_dropped_d = perf_dropped_q + 32'd1;
        end
        if (ev_stall && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed testbench for fetch_queue (WIDTH=32, DEPTH=4). Inputs are driven
//   1 time unit after the rising edge and outputs compared 1 unit later.
//   Define FETCH_QUEUE_PERF_EN for both RTL and bench to check the counters.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   mem_outstanding;

    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;

    fetch_queue_if #(.WIDTH(32)) bus ();

    fetch_queue #(
        .WIDTH(32),
        .DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef FETCH_QUEUE_PERF_EN
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped),
        .perf_stall   (perf_stall),
`endif
        .bus          (bus)
    );

`ifndef FETCH_QUEUE_PERF_EN
    assign perf_fetched = '0;
    assign perf_dropped = '0;
    assign perf_stall   = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side legality: a response must have an accepted request behind it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_outstanding <= 0;
        end else begin
            if (bus.imem_rsp_valid) begin
                assert (mem_outstanding > 0)
                    else $error("illegal imem response with nothing outstanding");
            end
            mem_outstanding <= mem_outstanding + (bus.pc_ready ? 1 : 0)
                               - (bus.imem_rsp_valid ? 1 : 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive all bench-owned inputs, then let combinational outputs settle.
    task automatic drive(input logic pv, input logic [31:0] p, input logic rr,
                         input logic rv, input logic [31:0] d, input logic ir,
                         input logic rdr);
        bus.pc_valid       = pv;
        bus.pc             = p;
        bus.imem_req_ready = rr;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = d;
        bus.instr_ready    = ir;
        bus.redirect       = rdr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // ---- Reset: outputs quiet even with a valid PC and ready memory ----
        rst = 1'b0;
        #1;
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_pc_ready", 32'(bus.pc_ready), 32'd0);
        step();
        step();
        rst = 1'b1;
        idle();
        step();

        // ---- Single fetch ----
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("s1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_eq("s1_pc_ready", 32'(bus.pc_ready), 32'd1);
        check_eq("s1_req_addr", bus.imem_req_addr, 32'h0);
        step();
        idle();
        check_eq("s1_empty", 32'(bus.instr_valid), 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b0);
        check_eq("s1_no_bypass", 32'(bus.instr_valid), 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("s1_instr_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("s1_instr", bus.instr, 32'h0050_0093);
        check_eq("s1_instr_pc", bus.instr_pc, 32'h0);
        step();
        idle();
        check_eq("s1_drained", 32'(bus.instr_valid), 32'd0);

        // ---- Fill to full, dequeue one, 5th PC accepted next cycle ----
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            check_eq("s2_issue", 32'(bus.pc_ready), 32'd1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10, 1'b1, 1'b1, 32'hA000_0000 | 32'(i * 4), 1'b0, 1'b0);
            check_eq("s2_full_block", 32'(bus.pc_ready), 32'd0);
            step();
        end
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("s2_head_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("s2_head_pc", bus.instr_pc, 32'h0);
        check_eq("s2_head_instr", bus.instr, 32'hA000_0000);
        check_eq("s2_no_same_cycle", 32'(bus.pc_ready), 32'd0);
        step();
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("s2_fifth_issue", 32'(bus.pc_ready), 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hA000_0010, 1'b0, 1'b0);
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            check_eq("s2_order_pc", bus.instr_pc, 32'(i * 4));
            check_eq("s2_order_instr", bus.instr, 32'hA000_0000 | 32'(i * 4));
            step();
        end
        idle();
        check_eq("s2_drained", 32'(bus.instr_valid), 32'd0);

        // ---- Memory stall ----
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            check_eq("s3_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check_eq("s3_stalled", 32'(bus.pc_ready), 32'd0);
            step();
        end
        drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("s3_accept", 32'(bus.pc_ready), 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("s3_instr_pc", bus.instr_pc, 32'h40);
        check_eq("s3_instr", bus.instr, 32'h33);
        step();
        idle();
        check_eq("s3_single_slot", 32'(bus.instr_valid), 32'd0);

        // ---- Redirect with two fetches in flight ----
        drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h24, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("s4_redir_no_req", 32'(bus.imem_req_valid), 32'd0);
        check_eq("s4_redir_no_ready", 32'(bus.pc_ready), 32'd0);
        step();
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("s4_new_issue", 32'(bus.pc_ready), 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0020, 1'b0, 1'b0);
        check_eq("s4_drop1", 32'(bus.instr_valid), 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0024, 1'b0, 1'b0);
        check_eq("s4_drop2", 32'(bus.instr_valid), 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 1'b0, 1'b0);
        check_eq("s4_drop3", 32'(bus.instr_valid), 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("s4_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("s4_instr", bus.instr, 32'h13);
        check_eq("s4_instr_pc", bus.instr_pc, 32'h100);
        step();
        idle();
        check_eq("s4_drained", 32'(bus.instr_valid), 32'd0);

        // ---- Redirect coincident with response and dequeue ----
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hB000_0200, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hB000_0204, 1'b1, 1'b1);
        check_eq("s5_pre_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("s5_pre_pc", bus.instr_pc, 32'h200);
        step();
        drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("s5_flushed", 32'(bus.instr_valid), 32'd0);
        check_eq("s5_issue", 32'(bus.pc_ready), 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0BAD_0208, 1'b0, 1'b0);
        check_eq("s5_stale_wait", 32'(bus.instr_valid), 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
        check_eq("s5_no_stale", 32'(bus.instr_valid), 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("s5_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("s5_instr", bus.instr, 32'h77);
        check_eq("s5_instr_pc", bus.instr_pc, 32'h300);
        step();
        idle();
        check_eq("s5_drained", 32'(bus.instr_valid), 32'd0);

        // ---- Asynchronous reset mid-stream with three entries queued ----
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hC000_0400 + 32'(i * 4), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h40C, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("s6_pre_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("s6_pre_head", bus.instr_pc, 32'h400);
        check_eq("s6_pre_req", 32'(bus.imem_req_valid), 32'd1);
        check_eq("s6_pre_ready", 32'(bus.pc_ready), 32'd1);
`ifdef FETCH_QUEUE_PERF_EN
        check_eq("perf_fetched", perf_fetched, 32'd13);
        check_eq("perf_dropped", perf_dropped, 32'd4);
        check_eq("perf_stall", perf_stall, 32'd6);
`endif
        #2;
        rst = 1'b0;
        #1;
        check_eq("s6_async_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("s6_async_req", 32'(bus.imem_req_valid), 32'd0);
        check_eq("s6_async_ready", 32'(bus.pc_ready), 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
        check_eq("perf_fetched_rst", perf_fetched, 32'd0);
        check_eq("perf_dropped_rst", perf_dropped, 32'd0);
        check_eq("perf_stall_rst", perf_stall, 32'd0);
`endif
        idle();
        step();
        step();
        rst = 1'b1;
        step();
        drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("s6_post_empty", 32'(bus.instr_valid), 32'd0);
        check_eq("s6_post_issue", 32'(bus.pc_ready), 32'd1);
        step();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC unit.
- Takes each PC, issues an in-order request to instruction memory, and buffers the returned instructions with their PCs in a DEPTH-entry queue.
- Delivers {instr, pc} pairs to decode over a valid/ready handshake.
- Back-pressures the PC unit when the queue has no free slot.
- On redirect (taken branch/jump), flushes all entries and drops responses still in flight.

Parameters:
- WIDTH, 32, address and instruction width
- DEPTH, 4, queue entries; power of two, >=2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- pc  input  WIDTH  fetch address from PC unit
- pc_valid  input  1  pc is valid this cycle
- pc_ready  output  1  request for pc accepted this cycle
- redirect  input  1  flush: discard queue and in-flight fetches
- imem_req_valid  output  1  memory request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  WIDTH  request address (= pc)
- imem_rsp_valid  input  1  response valid; always accepted, in order
- imem_rsp_data  input  WIDTH  fetched instruction
- instr_valid  output  1  head entry filled
- instr_ready  input  1  decode consumes head
- instr  output  WIDTH  head instruction
- instr_pc  output  WIDTH  head PC

Behaviour:
- Storage: DEPTH slots of {pc, instr}.
- Pointers: alloc_ptr, fill_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Counters: used (slots allocated, 0..DEPTH) and discard (0..DEPTH), each $clog2(DEPTH)+1 bits.
- Issue:
  - can_issue = (used + discard < DEPTH) && !redirect.
  - imem_req_valid = pc_valid && can_issue; imem_req_addr = pc.
  - pc_ready = imem_req_valid && imem_req_ready.
  - On pc_ready: slot[alloc_ptr].pc <= pc; alloc_ptr++; used++.
- Response:
  - If discard > 0: response dropped, discard--.
  - Else: slot[fill_ptr].instr <= imem_rsp_data; fill_ptr++.
  - A response with no outstanding request (alloc==fill and discard==0) is illegal and ignored; the bench asserts on it.
- Output:
  - instr_valid = (filled count > 0), where filled = fill_ptr - rd_ptr, tracked with an extra wrap bit.
  - instr / instr_pc come from slot[rd_ptr], combinational from registers.
  - On instr_valid && instr_ready: rd_ptr++; used--.
- Latency:
  - Minimum 1 cycle from response to instr_valid.
  - A response arriving on an empty queue is visible the next cycle.
- Simultaneous events:
  - Issue, response and dequeue may all occur in one cycle; used and filled are updated by the net change.
  - Queue full (used+discard==DEPTH): pc_ready=0 while still dequeueing and filling.
  - A dequeue freeing a slot allows issue from the next cycle, not combinationally in the same cycle.
- Redirect (registered flush, takes priority):
  - alloc_ptr, fill_ptr, rd_ptr <= 0; used <= 0; instr_valid low next cycle.
  - discard <= discard + (allocated-but-unfilled count), computed before the flush.
  - A response in the same cycle as redirect is dropped, and the discard arithmetic accounts for it.
  - No request is issued in the redirect cycle.
  - A dequeue handshake in the redirect cycle is ignored; decode must also squash that instruction.
- Reset (rst low, asynchronous): all pointers and counters 0; instr_valid=0, imem_req_valid=0, pc_ready=0. Slot contents are not reset.
- Reset mid-operation: outstanding memory responses after reset release are the memory's responsibility. The memory is reset on the same rst.

Optional Feature:
- Macro FETCH_QUEUE_PERF_EN.
- When defined, adds output ports:
  - perf_fetched (32 bits): count of responses written into the queue.
  - perf_dropped (32 bits): count of responses discarded.
  - perf_stall (32 bits): cycles with pc_valid=1 and can_issue=0.
- Counters reset to 0 on rst, saturate at all-ones, and are unaffected by redirect.
- When undefined, these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then single fetch: pc=0x0, imem_req_ready=1, response 0x00500093 two cycles later -> instr_valid next cycle with instr=0x00500093, instr_pc=0x0; consumed with instr_ready=1.
- Fill to full: PCs 0x0,0x4,0x8,0xC issued, instr_ready=0, responses returned -> pc_ready=0 on the 5th PC (0x10). One dequeue -> 0x10 accepted the following cycle; order 0x0..0x10 is preserved on output.
- Memory stall: imem_req_ready=0 for 3 cycles with pc_valid=1 -> pc_ready=0 and no slot allocated; request accepted on the cycle ready rises.
- Redirect with 2 in flight: issue 0x20, 0x24, assert redirect before either response -> next two responses dropped and instr_valid stays 0. Next fetch 0x100 returns 0x13 -> instr_pc=0x100.
- Redirect coincident with response and dequeue -> queue empty next cycle, discard count correct, no stale instruction ever presented.
- Async reset asserted mid-stream with 3 entries queued -> instr_valid, imem_req_valid and pc_ready fall immediately without a clock edge. With FETCH_QUEUE_PERF_EN defined, perf_fetched and perf_dropped match the counts from the previous scenarios.
